// File: rtl/telemetry_arbiter_pkg.sv
// Shared types and constants for the telemetry arbiter.
// The optional checksum is controlled by the TELEM_CHECKSUM_EN macro.
package telemetry_arbiter_pkg;

    // Default first header byte; the receiver resynchronises on it.
    localparam logic [7:0] TELEM_SYNC_DEFAULT = 8'hA5;

    // State encodings kept as plain constants so the state register is a flat vector.
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_HDR_SYNC = 3'd1;
    localparam logic [2:0] ST_HDR_ID   = 3'd2;
    localparam logic [2:0] ST_PAYLOAD  = 3'd3;
    localparam logic [2:0] ST_CKSUM    = 3'd4;

    // Typed view of the same encodings, used for the debug state output.
    typedef enum logic [2:0] {
        TA_IDLE     = 3'd0,
        TA_HDR_SYNC = 3'd1,
        TA_HDR_ID   = 3'd2,
        TA_PAYLOAD  = 3'd3,
        TA_CKSUM    = 3'd4
    } telem_arb_state_t;

endpackage

// File: rtl/telemetry_arbiter_rr_pick.sv
// Combinational round-robin picker: the first requester strictly after
// the pointer wins, wrapping around, so the pointer itself is served last.
module telemetry_arbiter_rr_pick
    import telemetry_arbiter_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [IW-1:0] cand;

    // Scan the requesters in priority order starting one past the pointer.
    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any      = 1'b1;
                gnt[cand] = 1'b1;
                idx      = cand;
            end
        end
    end

endmodule

// File: rtl/telemetry_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among
// telemetry producers. Each packet goes out as SYNC_BYTE, source index,
// payload bytes and, when TELEM_CHECKSUM_EN is defined, an XOR checksum
// covering the index and payload.
// Handshakes: a payload byte moves when src_valid[g] and src_ready[g] are
// both high on a clock edge; src_ready only rises for the granted source in
// a free slot (uart_ready high, no start this cycle, no holdoff), and a
// uart_start pulse launches the registered uart_data, which then holds.
module telemetry_arbiter
    import telemetry_arbiter_pkg::*;
#(
    parameter  int          SYSCLK_FREQ    = 100_000_000,
    parameter  int          NUM_SRC        = 4,
    parameter  logic [7:0]  SYNC_BYTE      = TELEM_SYNC_DEFAULT,
    parameter  int          TIMEOUT_CYCLES = 100_000,
    localparam int          IW             = $clog2(NUM_SRC)
) (
    input  logic                   sclk,
    input  logic                   rstn,
    input  logic [NUM_SRC-1:0]     src_valid,
    input  logic [8*NUM_SRC-1:0]   src_data,
    input  logic [NUM_SRC-1:0]     src_last,
    output logic [NUM_SRC-1:0]     src_ready,
    input  logic                   uart_ready,
    output logic                   uart_start,
    output logic [7:0]             uart_data,
    output logic [NUM_SRC-1:0]     grant,
    output logic                   busy,
    output logic                   timeout_err,
    output logic [IW-1:0]          err_src,
    output telem_arb_state_t       state_dbg
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    // Reject nonsensical configurations at elaboration time.
    if (SYSCLK_FREQ <= 0 || NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
        $error("telemetry_arbiter: unsupported parameter set");
    end

    logic [2:0]          state;
    logic [NUM_SRC-1:0]  grant_r;
    logic [IW-1:0]       gidx;
    logic [IW-1:0]       ptr;
    logic                start_r;
    logic                holdoff;
    logic [7:0]          data_r;
    logic [CW-1:0]       tcnt;
    logic                to_r;
    logic [IW-1:0]       err_r;
`ifdef TELEM_CHECKSUM_EN
    logic [7:0]          xsum;
`endif

    logic [NUM_SRC-1:0]  pick_gnt;
    logic [IW-1:0]       pick_idx;
    logic                pick_any;
    logic                slot;
    logic                g_valid;
    logic                g_last;
    logic [7:0]          g_data;
    logic                xfer;

    telemetry_arbiter_rr_pick #(.N(NUM_SRC)) u_rr_pick (
        .req (src_valid),
        .ptr (ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Select the granted source's byte lane and derive the free-slot condition.
    always_comb begin
        g_data = 8'h00;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gidx == IW'(i)) g_data = src_data[8*i +: 8];
        end
        g_valid = src_valid[gidx];
        g_last  = src_last[gidx];
        slot    = uart_ready && !start_r && !holdoff;
        xfer    = (state == ST_PAYLOAD) && slot && g_valid;
    end

    assign src_ready   = (state == ST_PAYLOAD && slot) ? grant_r : '0;
    assign uart_start  = start_r;
    assign uart_data   = data_r;
    assign grant       = grant_r;
    assign busy        = (state != ST_IDLE);
    assign timeout_err = to_r;
    assign err_src     = err_r;
    assign state_dbg   = telem_arb_state_t'(state);

    // Packet sequencer: arbitration, header/payload/checksum sending, stall abort.
    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_IDLE;
            grant_r <= '0;
            gidx    <= '0;
            ptr     <= IW'(NUM_SRC - 1);
            start_r <= 1'b0;
            holdoff <= 1'b0;
            data_r  <= 8'h00;
            tcnt    <= '0;
            to_r    <= 1'b0;
            err_r   <= '0;
`ifdef TELEM_CHECKSUM_EN
            xsum    <= 8'h00;
`endif
        end else begin
            start_r <= 1'b0;
            holdoff <= start_r;
            to_r    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tcnt <= '0;
                    if (pick_any) begin
                        grant_r <= pick_gnt;
                        gidx    <= pick_idx;
                        state   <= ST_HDR_SYNC;
                    end
                end
                ST_HDR_SYNC: begin
                    if (slot) begin
                        start_r <= 1'b1;
                        data_r  <= SYNC_BYTE;
                        state   <= ST_HDR_ID;
                    end
                end
                ST_HDR_ID: begin
                    if (slot) begin
                        start_r <= 1'b1;
                        data_r  <= 8'(gidx);
`ifdef TELEM_CHECKSUM_EN
                        xsum    <= 8'(gidx);
`endif
                        state   <= ST_PAYLOAD;
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer) begin
                        start_r <= 1'b1;
                        data_r  <= g_data;
                        tcnt    <= '0;
`ifdef TELEM_CHECKSUM_EN
                        xsum    <= xsum ^ g_data;
                        if (g_last) state <= ST_CKSUM;
`else
                        if (g_last) begin
                            state   <= ST_IDLE;
                            ptr     <= gidx;
                            grant_r <= '0;
                        end
`endif
                    end else if (slot) begin
                        // Only free slots with nothing offered count as stall time.
                        if (tcnt == CW'(TIMEOUT_CYCLES - 1)) begin
                            to_r    <= 1'b1;
                            err_r   <= gidx;
                            tcnt    <= '0;
                            state   <= ST_IDLE;
                            ptr     <= gidx;
                            grant_r <= '0;
                        end else begin
                            tcnt <= tcnt + 1'b1;
                        end
                    end
                end
`ifdef TELEM_CHECKSUM_EN
                ST_CKSUM: begin
                    if (slot) begin
                        start_r <= 1'b1;
                        data_r  <= xsum;
                        state   <= ST_IDLE;
                        ptr     <= gidx;
                        grant_r <= '0;
                    end
                end
`endif
                default: begin
                    state   <= ST_IDLE;
                    grant_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_telemetry_arbiter.sv
// Directed bench for telemetry_arbiter: byte stream scoreboard, arbitration
// order, latency, stall abort, UART back-pressure and mid-packet reset.
module tb_telemetry_arbiter;
    import telemetry_arbiter_pkg::*;

    localparam int NS = 4;
    localparam int TO = 50;

    logic              sclk = 1'b0;
    logic              rstn = 1'b1;
    logic [NS-1:0]     src_valid;
    logic [8*NS-1:0]   src_data;
    logic [NS-1:0]     src_last;
    logic [NS-1:0]     src_ready;
    logic              uart_ready = 1'b1;
    logic              uart_start;
    logic [7:0]        uart_data;
    logic [NS-1:0]     grant;
    logic              busy;
    logic              timeout_err;
    logic [1:0]        err_src;
    telem_arb_state_t  state_dbg;

    telemetry_arbiter #(
        .SYSCLK_FREQ    (100_000_000),
        .NUM_SRC        (NS),
        .SYNC_BYTE      (8'hA5),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .sclk        (sclk),
        .rstn        (rstn),
        .src_valid   (src_valid),
        .src_data    (src_data),
        .src_last    (src_last),
        .src_ready   (src_ready),
        .uart_ready  (uart_ready),
        .uart_start  (uart_start),
        .uart_data   (uart_data),
        .grant       (grant),
        .busy        (busy),
        .timeout_err (timeout_err),
        .err_src     (err_src),
        .state_dbg   (state_dbg)
    );

    // Clock and cycle counter
    always #5 sclk = ~sclk;

    int cyc = 0;
    initial forever begin
        @(posedge sclk);
        cyc++;
    end

    // Scoreboard state
    int          compared   = 0;
    int          mismatched = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          start_cyc[$];
    logic [8:0]  sq[NS][$];
    int          to_cnt = 0;
    int          to_cyc = 0;
    logic        busy_at_to = 1'b1;
    logic        hold_win = 1'b0;
    int          hold_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Source drivers: each source presents the head of its byte queue; a byte
    // leaves the queue after an edge on which valid and ready were both high.
    initial begin
        logic [NS-1:0] fire;
        src_valid = '0;
        src_data  = '0;
        src_last  = '0;
        forever begin
            @(negedge sclk);
            fire = src_valid & src_ready;
            @(posedge sclk);
            #1;
            for (int i = 0; i < NS; i++) begin
                if (fire[i] && sq[i].size() > 0) void'(sq[i].pop_front());
                if (sq[i].size() > 0) begin
                    src_valid[i]      = 1'b1;
                    src_data[8*i +: 8] = sq[i][0][7:0];
                    src_last[i]       = sq[i][0][8];
                end else begin
                    src_valid[i]      = 1'b0;
                    src_data[8*i +: 8] = 8'h00;
                    src_last[i]       = 1'b0;
                end
            end
        end
    end

    // Output monitor: records launched bytes and checks per-cycle properties.
    initial begin
        int   last_s;
        logic prev_start;
        last_s     = -100;
        prev_start = 1'b0;
        forever begin
            @(negedge sclk);
            if (!rstn) begin
                last_s     = -100;
                prev_start = 1'b0;
            end else begin
                chk("grant_onehot", 32'($onehot0(grant)), 32'd1);
                chk("ready_quiet", 32'((uart_start || prev_start) && src_ready != '0), 32'd0);
                if (uart_start) begin
                    chk("start_gap", 32'((cyc - last_s) >= 3), 32'd1);
                    last_s = cyc;
                    got_q.push_back(uart_data);
                    start_cyc.push_back(cyc);
                end
                if (timeout_err) begin
                    to_cnt++;
                    to_cyc     = cyc;
                    busy_at_to = busy;
                end
                if (hold_win && (uart_start || src_ready != '0)) hold_bad++;
                prev_start = uart_start;
            end
        end
    end

    task automatic load_src(input int s, input logic [7:0] p[$], input logic with_last);
        for (int k = 0; k < p.size(); k++)
            sq[s].push_back({with_last && (k == p.size() - 1), p[k]});
    endtask

    task automatic exp_pkt(input logic [7:0] id, input logic [7:0] p[$], input logic full);
        logic [7:0] x;
        exp_q.push_back(8'hA5);
        exp_q.push_back(id);
        x = id;
        for (int k = 0; k < p.size(); k++) begin
            exp_q.push_back(p[k]);
            x = x ^ p[k];
        end
`ifdef TELEM_CHECKSUM_EN
        if (full) exp_q.push_back(x);
`else
        if (full) x = 8'h00;
`endif
    endtask

    task automatic wait_bytes(input string tag, input int n, input int maxc);
        int k;
        k = 0;
        while (got_q.size() < n && k < maxc) begin
            @(negedge sclk);
            k++;
        end
        chk(tag, 32'(got_q.size() >= n), 32'd1);
    endtask

    task automatic compare_stream(input string tag);
        chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            chk($sformatf("%s_b%0d", tag, k), 32'(got_q[k]), 32'(exp_q[k]));
        got_q.delete();
        exp_q.delete();
        start_cyc.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_uart_start"}, 32'(uart_start), 32'd0);
        chk({tag, "_uart_data"}, 32'(uart_data), 32'h00);
        chk({tag, "_src_ready"}, 32'(src_ready), 32'd0);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
        chk({tag, "_err_src"}, 32'(err_src), 32'd0);
    endtask

    task automatic do_reset();
        rstn       = 1'b0;
        uart_ready = 1'b1;
        hold_win   = 1'b0;
        for (int i = 0; i < NS; i++) sq[i].delete();
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        rstn = 1'b1;
        got_q.delete();
        exp_q.delete();
        start_cyc.delete();
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        logic [7:0] pk[$];
        logic [7:0] last_b;
        int         t0;
        int         k;

        // Reset state
        #1 rstn = 1'b0;
        #1;
        check_reset_outputs("rst");
        do_reset();

        // Source 1 alone: stream and header latency
        @(negedge sclk);
        t0 = cyc + 1;
        pk = '{8'h11, 8'h22, 8'h33};
        load_src(1, pk, 1'b1);
        exp_pkt(8'h01, pk, 1'b1);
        k = 0;
        while (grant == '0 && k < 20) begin
            @(negedge sclk);
            k++;
        end
        chk("t1_grant_cycle", 32'(cyc), 32'(t0 + 1));
        chk("t1_grant", 32'(grant), 32'b0010);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_bytes("t1_wait", exp_q.size(), 200);
        if (start_cyc.size() >= 2) begin
            chk("t1_sync_cycle", 32'(start_cyc[0]), 32'(t0 + 2));
            chk("t1_id_cycle", 32'(start_cyc[1]), 32'(t0 + 5));
        end else begin
            chk("t1_start_count", 32'(start_cyc.size()), 32'd2);
        end
        repeat (6) @(negedge sclk);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_grant_end", 32'(grant), 32'd0);
        last_b = exp_q[exp_q.size() - 1];
        chk("t1_data_held", 32'(uart_data), 32'(last_b));
        compare_stream("t1");

        // Sources 0 and 2 together from reset: 0 first, then 2
        do_reset();
        @(negedge sclk);
        pk = '{8'hA0, 8'hA1};
        load_src(0, pk, 1'b1);
        exp_pkt(8'h00, pk, 1'b1);
        pk = '{8'hC0};
        load_src(2, pk, 1'b1);
        exp_pkt(8'h02, pk, 1'b1);
        wait_bytes("t2_wait", exp_q.size(), 300);
        repeat (6) @(negedge sclk);
        compare_stream("t2");

        // Source 0 re-requests while source 3 waits: 0, 3, then 0 again
        do_reset();
        @(negedge sclk);
        pk = '{8'h01};
        load_src(0, pk, 1'b1);
        exp_pkt(8'h00, pk, 1'b1);
        pk = '{8'h03};
        load_src(3, pk, 1'b1);
        exp_pkt(8'h03, pk, 1'b1);
        pk = '{8'h02};
        load_src(0, pk, 1'b1);
        exp_pkt(8'h00, pk, 1'b1);
        wait_bytes("t3_wait", exp_q.size(), 400);
        repeat (6) @(negedge sclk);
        compare_stream("t3");

        // Source 2 stalls after one payload byte: abort after TO free slots
        @(negedge sclk);
        to_cnt = 0;
        pk = '{8'h5A};
        load_src(2, pk, 1'b0);
        exp_pkt(8'h02, pk, 1'b0);
        wait_bytes("t4_wait", 3, 200);
        k = 0;
        while (to_cnt == 0 && k < 150) begin
            @(negedge sclk);
            k++;
        end
        chk("t4_to_count", 32'(to_cnt), 32'd1);
        if (start_cyc.size() >= 3)
            chk("t4_to_cycle", 32'(to_cyc), 32'(start_cyc[2] + TO + 2));
        else
            chk("t4_start_count", 32'(start_cyc.size()), 32'd3);
        chk("t4_busy_at_abort", 32'(busy_at_to), 32'd0);
        chk("t4_err_src", 32'(err_src), 32'd2);
        repeat (60) @(negedge sclk);
        chk("t4_to_once", 32'(to_cnt), 32'd1);
        chk("t4_grant_idle", 32'(grant), 32'd0);
        compare_stream("t4");

        // UART back-pressure for 200 cycles mid-packet
        @(negedge sclk);
        hold_bad = 0;
        pk = '{8'h10, 8'h11, 8'h12, 8'h13};
        load_src(1, pk, 1'b1);
        exp_pkt(8'h01, pk, 1'b1);
        wait_bytes("t5_wait_pre", 3, 200);
        @(posedge sclk);
        #1;
        uart_ready = 1'b0;
        hold_win   = 1'b1;
        repeat (200) @(posedge sclk);
        hold_win = 1'b0;
        #1 uart_ready = 1'b1;
        chk("t5_hold_quiet", 32'(hold_bad), 32'd0);
        chk("t5_no_timeout", 32'(to_cnt), 32'd1);
        wait_bytes("t5_wait", exp_q.size(), 300);
        repeat (6) @(negedge sclk);
        chk("t5_err_src_held", 32'(err_src), 32'd2);
        compare_stream("t5");

        // Reset during PAYLOAD, then a fresh packet
        @(negedge sclk);
        pk = '{8'hE0, 8'hE1, 8'hE2};
        load_src(3, pk, 1'b1);
        wait_bytes("t6_wait_pre", 3, 200);
        @(posedge sclk);
        #2 rstn = 1'b0;
        #1;
        check_reset_outputs("t6_rst");
        do_reset();
        @(negedge sclk);
        pk = '{8'h77};
        load_src(0, pk, 1'b1);
        exp_pkt(8'h00, pk, 1'b1);
        wait_bytes("t6_wait", exp_q.size(), 200);
        repeat (6) @(negedge sclk);
        compare_stream("t6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
